// File: rtl/coolgirl_pkg.sv
// Shared MMC3 IRQ constants for the multicart mapper paths.
// Register decode keys are {A14, A13, A0} of a CPU write.
package coolgirl_pkg;

    localparam int IRQ_CNT_W = 8;

    localparam logic [2:0] MMC3_REG_IRQ_LATCH   = 3'b100;
    localparam logic [2:0] MMC3_REG_IRQ_RELOAD  = 3'b101;
    localparam logic [2:0] MMC3_REG_IRQ_DISABLE = 3'b110;
    localparam logic [2:0] MMC3_REG_IRQ_ENABLE  = 3'b111;

    function automatic logic [2:0] mmc3_reg_sel(
        input logic a14,
        input logic a13,
        input logic a0
    );
        return {a14, a13, a0};
    endfunction

endpackage

// File: rtl/mmc3_scanline_irq_if.sv
// CPU register-write bus seen by the scanline IRQ block.
// The cartridge side drives it, the IRQ block only listens.
interface mmc3_scanline_irq_if;

    logic        romsel;
    logic        cpu_rw_in;
    logic [14:0] cpu_addr_in;
    logic [7:0]  cpu_data_in;

    modport master (
        output romsel,
        output cpu_rw_in,
        output cpu_addr_in,
        output cpu_data_in
    );

    modport slave (
        input romsel,
        input cpu_rw_in,
        input cpu_addr_in,
        input cpu_data_in
    );

endinterface

// File: rtl/a12_edge_filter.sv
// PPU A12 synchronizer and low-time filter.
// Emits a one-cycle pulse for rises after a long enough low period.
module a12_edge_filter #(
    parameter int A12_LOW_MIN = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic m2,
    input  logic reset,
    input  logic ppu_a12,
    output logic a12_pulse
);

    localparam int LW = $clog2(A12_LOW_MIN + 1);
    localparam logic [LW-1:0] LOW_MAX = LW'(A12_LOW_MIN);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [LW-1:0]          low_cnt;
    logic                   a12_s;

    assign a12_s = sync_q[SYNC_STAGES-1];

    // Bring the asynchronous A12 into the m2 domain.
    always_ff @(posedge m2) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ppu_a12};
        end
    end

    // Measure how long A12 has been low, saturating at the threshold.
    always_ff @(posedge m2) begin
        if (reset) begin
            low_cnt <= '0;
        end else if (a12_s) begin
            low_cnt <= '0;
        end else if (low_cnt != LOW_MAX) begin
            low_cnt <= low_cnt + 1'b1;
        end
    end

    // low_cnt only reaches the threshold while A12 was low, so a high
    // a12_s with a saturated count is exactly a qualified 0->1 edge.
    assign a12_pulse = a12_s & (low_cnt == LOW_MAX);

endmodule

// File: rtl/mmc3_scanline_irq.sv
// MMC3-compatible scanline IRQ counter driven by filtered PPU A12 rises.
// Define COOLGIRL_MMC3_IRQ_ALT_EN for the rev A (alternate) IRQ behaviour.
module mmc3_scanline_irq
    import coolgirl_pkg::*;
#(
    parameter int A12_LOW_MIN = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  m2,
    input  logic                  reset,
    input  logic                  mapper_sel,
    mmc3_scanline_irq_if.slave    bus,
    input  logic                  ppu_a12,
    output logic                  irq,
    output logic [IRQ_CNT_W-1:0]  irq_counter
);

    logic [IRQ_CNT_W-1:0] latch_q, latch_d;
    logic [IRQ_CNT_W-1:0] counter_q, counter_d;
    logic                 reload_q, reload_d;
    logic                 irq_en_q, irq_en_d;
    logic                 pending_q, pending_d;

    logic                 a12_pulse;
    logic                 wr;
    logic [2:0]           reg_sel;
    logic                 wr_reload;
    logic                 clk_tick;

    a12_edge_filter #(
        .A12_LOW_MIN (A12_LOW_MIN),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_filter (
        .m2        (m2),
        .reset     (reset),
        .ppu_a12   (ppu_a12),
        .a12_pulse (a12_pulse)
    );

    assign wr = mapper_sel & ~bus.romsel & ~bus.cpu_rw_in;
    assign reg_sel = mmc3_reg_sel(bus.cpu_addr_in[14],
                                  bus.cpu_addr_in[13],
                                  bus.cpu_addr_in[0]);
    assign wr_reload = wr & (reg_sel == MMC3_REG_IRQ_RELOAD);
    assign clk_tick = a12_pulse & mapper_sel & ~wr_reload;

    // Next-state: scanline clocking first, CPU writes override it.
    always_comb begin
        latch_d   = latch_q;
        counter_d = counter_q;
        reload_d  = reload_q;
        irq_en_d  = irq_en_q;
        pending_d = pending_q;

        if (clk_tick) begin
            if (counter_q == '0 || reload_q) begin
                counter_d = latch_q;
                reload_d  = 1'b0;
            end else begin
                counter_d = counter_q - 1'b1;
            end
`ifdef COOLGIRL_MMC3_IRQ_ALT_EN
            if (irq_en_q &&
                ((counter_q == IRQ_CNT_W'(1) && !reload_q) ||
                 (reload_q && latch_q == '0))) begin
                pending_d = 1'b1;
            end
`else
            if (irq_en_q && counter_d == '0) begin
                pending_d = 1'b1;
            end
`endif
        end

        if (wr) begin
            unique case (reg_sel)
                MMC3_REG_IRQ_LATCH: begin
                    latch_d = bus.cpu_data_in;
                end
                MMC3_REG_IRQ_RELOAD: begin
                    counter_d = '0;
                    reload_d  = 1'b1;
                end
                MMC3_REG_IRQ_DISABLE: begin
                    irq_en_d  = 1'b0;
                    pending_d = 1'b0;
                end
                MMC3_REG_IRQ_ENABLE: begin
                    irq_en_d = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // IRQ register file, cleared by synchronous reset.
    always_ff @(posedge m2) begin
        if (reset) begin
            latch_q   <= '0;
            counter_q <= '0;
            reload_q  <= 1'b0;
            irq_en_q  <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            latch_q   <= latch_d;
            counter_q <= counter_d;
            reload_q  <= reload_d;
            irq_en_q  <= irq_en_d;
            pending_q <= pending_d;
        end
    end

    assign irq = ~(pending_q & mapper_sel);
    assign irq_counter = counter_q;

endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// Scoreboard bench for mmc3_scanline_irq: stimulus queues expected
// irq/irq_counter values per cycle, a monitor pops and compares them.
module tb_mmc3_scanline_irq;

    logic       m2 = 1'b0;
    logic       reset = 1'b1;
    logic       mapper_sel = 1'b1;
    logic       ppu_a12 = 1'b1;
    logic       irq;
    logic [7:0] irq_counter;

    mmc3_scanline_irq_if bus ();

    mmc3_scanline_irq #(
        .A12_LOW_MIN (3),
        .SYNC_STAGES (2)
    ) dut (
        .m2          (m2),
        .reset       (reset),
        .mapper_sel  (mapper_sel),
        .bus         (bus),
        .ppu_a12     (ppu_a12),
        .irq         (irq),
        .irq_counter (irq_counter)
    );

    always #5 m2 = ~m2;

    typedef struct {
        int         t;
        logic       irq;
        logic [7:0] cnt;
        string      name;
    } exp_t;

    exp_t q[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    task automatic expect_at(input int k, input logic i,
                             input logic [7:0] c, input string n);
        exp_t e;
        e.t = cyc + k;
        e.irq = i;
        e.cnt = c;
        e.name = n;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge m2);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus.romsel = 1'b0;
        bus.cpu_rw_in = 1'b0;
        bus.cpu_addr_in = a[14:0];
        bus.cpu_data_in = d;
        tick(1);
        bus.romsel = 1'b1;
        bus.cpu_rw_in = 1'b1;
    endtask

    task automatic a12(input int low, input logic i,
                       input logic [7:0] c, input string n);
        ppu_a12 = 1'b0;
        tick(low);
        ppu_a12 = 1'b1;
        expect_at(3, i, c, n);
        tick(4);
    endtask

    // Monitor: compare every expectation due on this cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge m2);
            #1;
            cyc = cyc + 1;
            while (q.size() > 0 && q[0].t <= cyc) begin
                e = q.pop_front();
                checks++;
                if (e.t < cyc) begin
                    errors++;
                    $display("FAIL %s: missed at cycle %0d", e.name, e.t);
                end else if (irq !== e.irq || irq_counter !== e.cnt) begin
                    errors++;
                    $display("FAIL %s: irq=%b cnt=%0d, want irq=%b cnt=%0d",
                             e.name, irq, irq_counter, e.irq, e.cnt);
                end
            end
        end
    end

    initial begin
        exp_t e;
        bus.romsel = 1'b1;
        bus.cpu_rw_in = 1'b1;
        bus.cpu_addr_in = '0;
        bus.cpu_data_in = '0;

        tick(2);
        expect_at(1, 1'b1, 8'd0, "reset");
        tick(1);
        reset = 1'b0;

        wr(16'hC000, 8'd3);
        wr(16'hC001, 8'd0);
        wr(16'hE001, 8'd0);
        a12(10, 1'b1, 8'd3, "p1_load");
        a12(10, 1'b1, 8'd2, "p2_dec");
        a12(10, 1'b1, 8'd1, "p3_dec");
        a12(10, 1'b0, 8'd0, "p4_irq");

        expect_at(1, 1'b1, 8'd0, "ack");
        wr(16'hE000, 8'd0);
        a12(10, 1'b1, 8'd3, "reload_after_ack");

        a12(2, 1'b1, 8'd3, "short1");
        a12(2, 1'b1, 8'd3, "short2");
        a12(10, 1'b1, 8'd2, "after_short");

        wr(16'hC000, 8'd0);
        wr(16'hC001, 8'd0);
        wr(16'hE001, 8'd0);
        a12(10, 1'b0, 8'd0, "zero_first");
        expect_at(1, 1'b1, 8'd0, "zero_ack");
        wr(16'hE000, 8'd0);
        wr(16'hE001, 8'd0);
`ifdef COOLGIRL_MMC3_IRQ_ALT_EN
        a12(10, 1'b1, 8'd0, "zero_rearm2");
        a12(10, 1'b1, 8'd0, "zero_rearm3");
`else
        a12(10, 1'b0, 8'd0, "zero_rearm2");
        a12(10, 1'b0, 8'd0, "zero_rearm3");
`endif
        expect_at(1, 1'b1, 8'd0, "zero_ack2");
        wr(16'hE000, 8'd0);

        wr(16'hC000, 8'd5);
        wr(16'hC001, 8'd0);
        a12(10, 1'b1, 8'd5, "load5");
        wr(16'hC000, 8'd7);
        ppu_a12 = 1'b0;
        tick(10);
        ppu_a12 = 1'b1;
        tick(2);
        expect_at(1, 1'b1, 8'd0, "c001_wins");
        wr(16'hC001, 8'd0);
        tick(2);
        a12(10, 1'b1, 8'd7, "reload7");

        wr(16'hC000, 8'd1);
        wr(16'hC001, 8'd0);
        wr(16'hE001, 8'd0);
        a12(10, 1'b1, 8'd1, "r_load1");
        a12(10, 1'b0, 8'd0, "r_irq");
        wr(16'hC000, 8'd2);
        a12(10, 1'b0, 8'd2, "r_cnt2_pend");
        reset = 1'b1;
        expect_at(1, 1'b1, 8'd0, "reset_mid");
        tick(1);
        reset = 1'b0;

        wr(16'hC000, 8'd4);
        wr(16'hC001, 8'd0);
        a12(10, 1'b1, 8'd4, "sel_load4");
        mapper_sel = 1'b0;
        wr(16'hC000, 8'd9);
        wr(16'hC001, 8'd0);
        a12(10, 1'b1, 8'd4, "sel_off_hold");
        mapper_sel = 1'b1;
        wr(16'hC001, 8'd0);
        a12(10, 1'b1, 8'd4, "sel_latch_kept");

        wr(16'hC000, 8'd0);
        wr(16'hC001, 8'd0);
        wr(16'hE001, 8'd0);
        a12(10, 1'b0, 8'd0, "sel_pend");
        mapper_sel = 1'b0;
        expect_at(1, 1'b1, 8'd0, "sel_masks_irq");
        tick(1);
        mapper_sel = 1'b1;
        expect_at(1, 1'b0, 8'd0, "sel_restores_irq");
        tick(4);

        while (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: never checked, due cycle %0d", e.name, e.t);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
